// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and remainder correction for the divider result path
package div_pkg;

  localparam int DIV_N = 4;

  typedef struct packed {
    logic [DIV_N-1:0] q;
    logic [DIV_N-1:0] r;
    logic             dz;
  } div_result_t;

  // Non-restoring division leaves a negative partial remainder one divisor short;
  // adding the divisor back restores the true remainder.
  function automatic logic [DIV_N-1:0] div_correct(input logic [DIV_N:0]   pr,
                                                   input logic [DIV_N-1:0] d);
    logic [DIV_N:0] sum;
    sum = pr + {1'b0, d};
    return pr[DIV_N] ? sum[DIV_N-1:0] : pr[DIV_N-1:0];
  endfunction

endpackage

// File: rtl/div_result_fifo.sv
// rtl/div_result_fifo.sv - in-order result FIFO with occupancy count
module div_result_fifo
  import div_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  div_result_t   din,
  input  logic          pop,
  output div_result_t   dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("div_result_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  div_result_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses pushes even if a pop happens in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/div_result_stage.sv
// rtl/div_result_stage.sv - remainder restoration, divide-by-zero flag and result queue
module div_result_stage
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_q,
  input  logic [N:0]   in_pr,
  input  logic [N-1:0] in_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic [N-1:0] out_r,
  output logic         out_dz,
  output logic [7:0]   out_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  generate
    if (N != DIV_N) begin : g_bad_n
      $error("div_result_stage: N must match div_pkg::DIV_N");
    end
  endgenerate

  div_result_t   wr_data;
  div_result_t   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_occupancy;
  logic          push;
  logic          pop;

  // Handshake flags come from the registered occupancy only, never from out_ready.
  assign in_ready  = !fifo_full;
  assign out_valid = (fifo_occupancy != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Build the finished result; a zero divisor bypasses correction and saturates q.
  always_comb begin
    wr_data    = '0;
    wr_data.dz = (in_d == '0);
    if (wr_data.dz) begin
      wr_data.q = '1;
      wr_data.r = in_pr[N-1:0];
    end else begin
      wr_data.q = in_q;
      wr_data.r = div_correct(in_pr, in_d);
    end
  end

  div_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_occupancy)
  );

  // Present the head only while it is valid so stale storage never leaks out.
  always_comb begin
    out_q  = '0;
    out_r  = '0;
    out_dz = 1'b0;
    if (!fifo_empty) begin
      out_q  = head.q;
      out_r  = head.r;
      out_dz = head.dz;
    end
  end

  // Delivered-result counter, wraps modulo 256.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (pop) begin
      out_cnt <= out_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_div_result_stage.sv
// tb/tb_div_result_stage.sv - scoreboard bench for div_result_stage
module tb_div_result_stage;
  import div_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_q;
  logic [4:0] in_pr;
  logic [3:0] in_d;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_q;
  logic [3:0] out_r;
  logic       out_dz;
  logic [7:0] out_cnt;

  div_result_t sb[$];
  div_result_t got;
  div_result_t exp_h;
  logic        popped;
  int          n_cmp;
  int          n_bad;
  int          underflows;
  int          pops;

  div_result_stage #(.N(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_q      (in_q),
    .in_pr     (in_pr),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dz    (out_dz),
    .out_cnt   (out_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic div_result_t model(input logic [3:0] q, input logic [4:0] pr,
                                        input logic [3:0] d);
    div_result_t res;
    int v;
    if (d == 4'd0) begin
      res.q  = 4'hF;
      res.r  = pr[3:0];
      res.dz = 1'b1;
    end else begin
      v = pr[4] ? int'(pr) - 32 : int'(pr);
      if (v < 0) v = v + int'(d);
      res.q  = q;
      res.r  = 4'(v & 15);
      res.dz = 1'b0;
    end
    return res;
  endfunction

  task automatic tick();
    popped = 1'b0;
    if (out_valid === 1'b1 && out_ready) begin
      popped = 1'b1;
      got    = {out_q, out_r, out_dz};
      if (sb.size() > 0) exp_h = sb.pop_front();
      else begin
        exp_h = '1;
        underflows++;
      end
    end
    if (in_valid && in_ready === 1'b1) sb.push_back(model(in_q, in_pr, in_d));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic set_in(input logic [3:0] q, input logic [4:0] pr, input logic [3:0] d);
    in_q  = q;
    in_pr = pr;
    in_d  = d;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    set_in(4'd0, 5'd0, 4'd0);
    tick(); tick();
    rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if ({out_q, out_r, out_dz} !== 9'd0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", {out_q, out_r, out_dz}); end
    n_cmp++; if (out_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_out_cnt: got %0d expected 0", out_cnt); end
  endtask

  task automatic test_positive();
    in_valid = 1'b1; set_in(4'b0100, 5'b00001, 4'b0011);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pos_no_bypass: got %b expected 0", out_valid); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pos_valid: got %b expected 1", out_valid); end
    n_cmp++; if ({out_q, out_r, out_dz} !== {4'd4, 4'd1, 1'b0}) begin n_bad++; $display("FAIL pos_result: got %h expected %h", {out_q, out_r, out_dz}, {4'd4, 4'd1, 1'b0}); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (popped !== 1'b1 || got !== exp_h) begin n_bad++; $display("FAIL pos_scoreboard: got %h expected %h popped %b", got, exp_h, popped); end
    n_cmp++; if (out_cnt !== 8'd1) begin n_bad++; $display("FAIL pos_out_cnt: got %0d expected 1", out_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pos_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_negative();
    in_valid = 1'b1; set_in(4'b0010, 5'b11101, 4'b0101);
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_q, out_r, out_dz} !== {1'b1, 4'd2, 4'd2, 1'b0}) begin n_bad++; $display("FAIL neg_result: got %h expected %h", {out_valid, out_q, out_r, out_dz}, {1'b1, 4'd2, 4'd2, 1'b0}); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (popped !== 1'b1 || got !== exp_h) begin n_bad++; $display("FAIL neg_scoreboard: got %h expected %h popped %b", got, exp_h, popped); end
    n_cmp++; if (out_cnt !== 8'd2) begin n_bad++; $display("FAIL neg_out_cnt: got %0d expected 2", out_cnt); end
  endtask

  task automatic test_div_zero();
    in_valid = 1'b1; set_in(4'b1111, 5'b00111, 4'b0000);
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_q, out_r, out_dz} !== {1'b1, 4'd15, 4'd7, 1'b1}) begin n_bad++; $display("FAIL dz_result: got %h expected %h", {out_valid, out_q, out_r, out_dz}, {1'b1, 4'd15, 4'd7, 1'b1}); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (popped !== 1'b1 || got !== exp_h) begin n_bad++; $display("FAIL dz_scoreboard: got %h expected %h popped %b", got, exp_h, popped); end
    n_cmp++; if (out_cnt !== 8'd3) begin n_bad++; $display("FAIL dz_out_cnt: got %0d expected 3", out_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; set_in(4'd1, 5'd1, 4'd2);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_a: got %b expected 1", in_ready); end
    tick();
    set_in(4'd3, 5'b11110, 4'd4);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_b: got %b expected 1", in_ready); end
    tick();
    set_in(4'd0, 5'd3, 4'd0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %b expected 0", in_ready); end
    tick();
    n_cmp++; if ({in_ready, out_valid, out_q} !== {1'b0, 1'b1, 4'd1}) begin n_bad++; $display("FAIL bp_hold: got %h expected %h", {in_ready, out_valid, out_q}, {1'b0, 1'b1, 4'd1}); end
    out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_no_comb_ready: got %b expected 0", in_ready); end
    tick();
    n_cmp++; if (popped !== 1'b1 || got !== exp_h) begin n_bad++; $display("FAIL bp_pop_a: got %h expected %h popped %b", got, exp_h, popped); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_return: got %b expected 1", in_ready); end
    tick();
    n_cmp++; if (popped !== 1'b1 || got !== exp_h) begin n_bad++; $display("FAIL bp_pop_b: got %h expected %h popped %b", got, exp_h, popped); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (popped !== 1'b1 || got !== exp_h) begin n_bad++; $display("FAIL bp_pop_c: got %h expected %h popped %b", got, exp_h, popped); end
    n_cmp++; if ({out_valid, out_cnt} !== {1'b0, 8'd3}) begin n_bad++; $display("FAIL bp_end: got valid/cnt %h expected %h", {out_valid, out_cnt}, {1'b0, 8'd3}); end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    pops = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_in(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      if (i > 0) begin
        n_cmp++; if ({out_valid, in_ready} !== 2'b11) begin n_bad++; $display("FAIL stream_occ1 cyc %0d: got %b expected 11", i, {out_valid, in_ready}); end
      end
      tick();
      n_cmp++; if (popped !== (i > 0)) begin n_bad++; $display("FAIL stream_rate cyc %0d: got %b expected %b", i, popped, (i > 0)); end
      if (popped) begin
        pops++;
        n_cmp++; if (got !== exp_h) begin n_bad++; $display("FAIL stream_data cyc %0d: got %h expected %h", i, got, exp_h); end
        if (pops == 256) begin
          n_cmp++; if (out_cnt !== 8'd0) begin n_bad++; $display("FAIL stream_wrap: got %0d expected 0", out_cnt); end
        end
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (popped !== 1'b1 || got !== exp_h) begin n_bad++; $display("FAIL stream_last: got %h expected %h popped %b", got, exp_h, popped); end
    n_cmp++; if ({out_valid, out_cnt} !== {1'b0, 8'd44}) begin n_bad++; $display("FAIL stream_end: got valid/cnt %h expected %h", {out_valid, out_cnt}, {1'b0, 8'd44}); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) in_valid = 1'b0;
      set_in(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      tick();
      if (popped) begin
        n_cmp++; if (got !== exp_h) begin n_bad++; $display("FAIL rmid_fill cyc %0d: got %h expected %h", i, got, exp_h); end
      end
    end
    out_ready = 1'b0; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_cnt, in_ready, out_valid} !== {8'd5, 1'b0, 1'b1}) begin n_bad++; $display("FAIL rmid_pre: got %h expected %h", {out_cnt, in_ready, out_valid}, {8'd5, 1'b0, 1'b1}); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    sb.delete();
    n_cmp++; if ({out_valid, in_ready, out_cnt} !== {1'b0, 1'b1, 8'd0}) begin n_bad++; $display("FAIL rmid_flags: got %h expected %h", {out_valid, in_ready, out_cnt}, {1'b0, 1'b1, 8'd0}); end
    n_cmp++; if ({out_q, out_r, out_dz} !== 9'd0) begin n_bad++; $display("FAIL rmid_outputs: got %h expected 0", {out_q, out_r, out_dz}); end
    in_valid = 1'b1; set_in(4'd9, 5'd4, 4'd6);
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_q, out_r, out_dz} !== {1'b1, 4'd9, 4'd4, 1'b0}) begin n_bad++; $display("FAIL rmid_after: got %h expected %h", {out_valid, out_q, out_r, out_dz}, {1'b1, 4'd9, 4'd4, 1'b0}); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (popped !== 1'b1 || got !== exp_h || out_cnt !== 8'd1) begin n_bad++; $display("FAIL rmid_pop: got %h cnt %0d expected %h cnt 1", got, out_cnt, exp_h); end
  endtask

  task automatic test_scoreboard_drained();
    n_cmp++; if (underflows !== 0) begin n_bad++; $display("FAIL sb_underflow: got %0d expected 0", underflows); end
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; underflows = 0; pops = 0;
    popped = 1'b0; got = '0; exp_h = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_q = '0; in_pr = '0; in_d = '0;
    @(negedge clk);
    test_reset();
    test_positive();
    test_negative();
    test_div_zero();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_scoreboard_drained();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_result_stage.md
# div_result_stage

Output stage directly downstream of the 4-bit non-restoring divider. It accepts the divider's raw quotient and final partial remainder plus the divisor used, and applies the final remainder restoration step. It also flags divide-by-zero and queues finished results in a small FIFO behind a valid/ready handshake, so the divider can start its next division while the consumer stalls.

## Interface
Parameters:
- `N`, default 4: dividend/divisor/quotient width; the partial remainder is N+1 bits.
- `DEPTH`, default 2: result FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  divider result available this cycle.
- `in_ready`  out  1  stage can accept; equals "FIFO not full".
- `in_q`  in  N  raw quotient bits from divider (already binary: bit = ~sign of each step).
- `in_pr`  in  N+1  final partial remainder, two's complement.
- `in_d`  in  N  divisor used for this division.
- `out_valid`  out  1  FIFO head holds a result.
- `out_ready`  in  1  consumer accepts head this cycle.
- `out_q`  out  N  quotient.
- `out_r`  out  N  corrected remainder.
- `out_dz`  out  1  divide-by-zero flag for this result.
- `out_cnt`  out  8  count of results delivered; wraps modulo 256.

## Operation
- Accept (push) when `in_valid && in_ready`. Deliver (pop) when `out_valid && out_ready`.
- Correction, combinational before the FIFO write:
  - If `in_pr[N]==1`, r = (in_pr + {1'b0,in_d}) mod 2^(N+1), take the low N bits.
  - Otherwise r = `in_pr[N-1:0]`.
  - q = `in_q`.
- Divide-by-zero: if `in_d==0`, then dz=1, q forced to all ones, and r = `in_pr[N-1:0]` with no correction.
- FIFO is strictly in order, DEPTH entries, with read/write pointers and an occupancy count.
  - Pointers wrap modulo DEPTH.
  - Occupancy runs 0..DEPTH.
- Push and pop in the same cycle are legal when 0 < occupancy < DEPTH; occupancy is unchanged.
- At occupancy 0, a push is not visible at the output in the same cycle (no bypass).
- At occupancy DEPTH, `in_ready`=0 and no push occurs, even if a pop happens that cycle.
  - `in_ready` never depends combinationally on `out_ready`.
- `out_q`, `out_r` and `out_dz` show the FIFO head when `out_valid`=1, and are driven to 0 when empty.
- `out_cnt` increments by 1 on each pop and wraps 255 -> 0.
- `in_valid` while `in_ready`=0: no action. Upstream must hold its data.

## Timing
- Reset (edge with `rst_n`=0):
  - occupancy=0, pointers=0, `out_cnt`=0.
  - `out_valid`=0, `in_ready`=1.
  - `out_q`/`out_r`/`out_dz`=0.
- Reset mid-operation discards all queued entries; no partial pop is counted.
- Latency: push at edge k, into an empty FIFO, gives `out_valid`=1 after edge k, i.e. usable at edge k+1.
- Throughput: one result per cycle sustained when `out_ready`=1.
- `out_valid` and `in_ready` are functions of registered occupancy only.
- Full to not-full: `in_ready` rises in the cycle after the pop edge.

## Structure
- Package `div_pkg` holds:
  - Localparam `DIV_N`=4.
  - Struct typedef `div_result_t` {q[N], r[N], dz}.
  - The correction function (pr, d) -> r, shared with the divider's testbench model.
- Sub-module `div_result_fifo`: generic DEPTH-entry FIFO of `div_result_t`, with push/pop/full/empty/count.
- The top holds the correction logic, dz detection and `out_cnt`.

## Test plan
- Positive remainder: push q=0100, pr=00001, d=0011 (13/3) into an empty stage.
  - Required: one cycle later out_valid=1, out_q=4, out_r=1, out_dz=0. After the pop, out_cnt=1.
- Negative remainder correction: push q=0010, pr=11101, d=0101 (12/5).
  - Required: out_q=2, out_r=2, out_dz=0.
- Divide-by-zero: push q=1111, pr=00111, d=0000.
  - Required: out_q=15, out_r=7, out_dz=1.
- Backpressure: with out_ready=0, hold in_valid=1 for 3 cycles with results A, B, C.
  - Required: A and B accepted, then in_ready=0 and C held.
  - Raise out_ready: A, B, C emerge in order, C is accepted the cycle after in_ready returns, and out_cnt ends at 3.
- Streaming and wrap: keep in_valid=out_ready=1 for 300 cycles.
  - Required: occupancy steady at 1 and one output per cycle.
  - out_cnt passes 255 -> 0 and ends at 300 mod 256 = 44.
- Reset mid-operation: with 2 entries queued and out_cnt=5, drive rst_n=0 for one edge.
  - Required: out_valid=0, in_ready=1, out_cnt=0, outputs 0.
  - A following push appears normally one cycle later.
